eth_avalon_txdma_fetch: RTL

- Avalon-MM pipelined read master that moves one transmit buffer from system memory into the 36-bit transmit DMA FIFO (dual-clock, show-ahead).
- Flow control uses the FIFO write-side fill level and counts its own reads still in flight, so the FIFO never overflows; the FIFO has overflow checking disabled.
- Sits between the TX descriptor engine, which supplies start/address/length, and the FIFO write port, in the FIFO write clock domain.

---
 rtl/eth_avalon_txdma_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/eth_avalon_txdma_fetch.sv
// Avalon-MM pipelined read master that copies one transmit buffer into the
// 36-bit TX DMA FIFO, with credit-based flow control against the FIFO fill level.
module eth_avalon_txdma_fetch #(
  parameter int FIFO_DEPTH = 1024,
  parameter int FIFO_AW    = 10,
  parameter int MAX_PEND   = 4,
  parameter int MARGIN     = 4,
  parameter int LEN_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [31:0]        start_addr,
  input  logic [LEN_W-1:0]   start_len,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [31:0]        av_address,
  output logic               av_read,
  input  logic               av_waitrequest,
  input  logic [31:0]        av_readdata,
  input  logic               av_readdatavalid,
  output logic [35:0]        fifo_data,
  output logic               fifo_wrreq,
  input  logic [FIFO_AW-1:0] fifo_wrusedw,
  input  logic               fifo_wrfull,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_FIN} state_t;

  localparam int CW = FIFO_AW + 1;

  state_t           state, state_nxt;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] words_q, issued_q, rcvd_q, words_start;
  logic [LEN_W:0]   len_plus3;
  logic [1:0]       last_bc_q;
  logic [3:0]       pend_q;
  logic             abort_q, stall_q;
  logic [CW-1:0]    credit;
  logic             credit_ok, abort_now, can_issue, accept, rvalid, active;
  logic             sop, eop;

  assign len_plus3   = {1'b0, start_len} + (LEN_W+1)'(3);
  assign words_start = {1'b0, len_plus3[LEN_W:2]};

  assign active    = (state == S_REQ) || (state == S_DRAIN);
  assign abort_now = abort_q || abort;
  // Sum is one bit wider than the fill level so it can never wrap.
  assign credit    = {1'b0, fifo_wrusedw} + CW'(pend_q) + CW'(1);
  assign credit_ok = credit <= CW'(FIFO_DEPTH - MARGIN);
  assign can_issue = (state == S_REQ) && !abort_now && (issued_q != words_q) &&
                     (pend_q < 4'(MAX_PEND)) && credit_ok && !fifo_wrfull;

  // Avalon read handshake: a request is accepted in a cycle where av_read is high
  // and av_waitrequest is low. Once raised, av_read and av_address stay put until
  // accepted, even if abort or the credit check would otherwise drop the request.
  assign av_read    = (state == S_REQ) && (stall_q || can_issue);
  assign accept     = av_read && !av_waitrequest;
  assign rvalid     = av_readdatavalid && active && (pend_q != 4'd0);
  assign av_address = addr_q;

  assign sop = (rcvd_q == '0);
  assign eop = ((rcvd_q + LEN_W'(1)) == words_q);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign aborted   = (state == S_FIN) && abort_q;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (words_start == '0) ? S_FIN : S_REQ;
      S_REQ:   if (!(av_read && av_waitrequest) &&
                   (abort_now || ((issued_q + LEN_W'(accept)) == words_q)))
                 state_nxt = S_DRAIN;
      S_DRAIN: if (pend_q == 4'd0) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      words_q    <= '0;
      issued_q   <= '0;
      rcvd_q     <= '0;
      last_bc_q  <= '0;
      pend_q     <= '0;
      abort_q    <= 1'b0;
      stall_q    <= 1'b0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
    end else begin
      state      <= state_nxt;
      stall_q    <= av_read && av_waitrequest;
      fifo_wrreq <= rvalid && !abort_now;
      if (state == S_IDLE) begin
        if (start) begin
          addr_q    <= {start_addr[31:2], 2'b00};
          words_q   <= words_start;
          issued_q  <= '0;
          rcvd_q    <= '0;
          last_bc_q <= start_len[1:0] - 2'd1;
          pend_q    <= '0;
          abort_q   <= 1'b0;
        end
      end else begin
        if (accept) begin
          addr_q   <= addr_q + 32'd4;
          issued_q <= issued_q + LEN_W'(1);
        end
        if (accept && !rvalid)      pend_q <= pend_q + 4'd1;
        else if (!accept && rvalid) pend_q <= pend_q - 4'd1;
        if (rvalid) begin
          rcvd_q    <= rcvd_q + LEN_W'(1);
          fifo_data <= {eop, sop, (eop ? last_bc_q : 2'd3), av_readdata};
        end
        if (active && abort) abort_q <= 1'b1;
      end
    end
  end

endmodule
